byte_encode_stream: RTL
=======================

Name: byte_encode_stream

Overview:
- Streaming ByteEncode_d stage directly downstream of the coefficient compressor.
- Consumes one d-bit compressed coefficient per handshake and packs 256 coefficients LSB-first into a byte stream of 32*d bytes.
- Feeds the ciphertext/public-key serializer.
- Bit accumulator with valid/ready handshakes on both sides; backpressure propagates upstream.

Parameters:
N_COEFF, 256, coefficients per polynomial; must be a multiple of 8.
COEFF_W, 12, coefficient input width; maximum supported d.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a polynomial, latches d.
d  input  4  bits per coefficient; legal range 1..12.
coeff  input  COEFF_W  compressed coefficient; only bits [d-1:0] are used.
coeff_valid  input  1  coeff is valid.
coeff_ready  output  1  block accepts coeff this cycle.
byte_data  output  8  packed output byte.
byte_valid  output  1  byte_data is valid.
byte_ready  input  1  downstream accepts byte.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse after the last byte is transferred.
err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async, rst_n low): state IDLE, accumulator=0, bit count=0, coefficient count=0.
  - All outputs 0: coeff_ready, byte_valid, byte_data, busy, done, err.
- Reset mid-polynomial aborts immediately. No done is issued. Partial bytes are discarded.
- States:
  - IDLE -> RUN on start with d in 1..12.
    - The start cycle latches d_q and clears the counters.
    - busy rises the next cycle.
  - start with d=0 or d>12 in IDLE: ignored; err pulses the following cycle; stays IDLE.
  - start while busy: ignored, no err.
  - RUN -> DONE when coefficient count=N_COEFF and bit count=0.
    - 256*d is always a multiple of 8, so no residue remains.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Accumulator: 20-bit register acc, 5-bit bit count cnt (0..19).
- coeff_ready = RUN && cnt<8 && coefficient count<N_COEFF. It is a registered-state function and does not depend on coeff_valid.
- Accept (coeff_valid && coeff_ready):
  - acc |= (coeff & ((1<<d_q)-1)) << cnt.
  - cnt += d_q.
  - coefficient count += 1.
- byte_valid = RUN && cnt>=8; byte_data = acc[7:0].
  - Both are driven from registers, so a byte appears the cycle after the accept that brings cnt to at least 8.
- Emit (byte_valid && byte_ready): acc >>= 8, cnt -= 8.
- Accept and emit never occur in the same cycle: coeff_ready needs cnt<8 and byte_valid needs cnt>=8.
- Backpressure: while byte_valid && !byte_ready, byte_data is held stable and coeff_ready stays 0.
- Bit order is LSB-first. Bit j of coefficient i lands at stream bit i*d+j; byte k holds stream bits 8k..8k+7.
- Coefficient bits above d_q are masked and never reach acc.
- Throughput:
  - d=8: one byte per two cycles.
  - d=12: three bytes per five cycles.
  - Documented limit; no overlap is required.

Optional Feature:
- Macro: BYTE_ENCODE_RANGE_CHECK_EN.
- Defined:
  - Extra output range_err (1 bit), sticky, cleared by reset or an accepted start.
  - Sets on an accepted coefficient with any bit set at or above d_q.
  - Also sets when d_q=12 and coeff>=3329.
  - Data path is unchanged; coefficients are still masked.
- Undefined: port absent, no checking logic.

Test Plan:
- d=1, 256 coefficients alternating 1,0, byte_ready=1 -> 32 bytes, all 0x55; done pulses once, one cycle after the last byte handshake; busy then 0.
- d=4, coeffs 0x3,0xA -> first byte 0xA3. Full polynomial of 0xF -> 128 bytes of 0xFF.
- d=12, coeffs 0xABC,0x123 -> bytes 0xBC,0x3A,0x12. Full polynomial -> exactly 384 bytes; coeff_ready never asserted after coefficient 256.
- d=10, byte_ready held low 5 cycles at byte 3 -> byte_data stable, byte_valid=1, coeff_ready=0 throughout; resumes with no loss. Total 320 bytes.
- start with d=0, then start with d=13 -> err pulses each time, busy stays 0. start with d=5 during RUN -> no effect on d_q.
- rst_n low after 100 coefficients at d=11 -> all outputs 0 asynchronously, no done. A new start with d=11 gives a fresh 352-byte stream.

Source files
------------

// File: rtl/byte_encode_stream_if.sv
// Coefficient-in / byte-out stream bundle for byte_encode_stream.
// master drives coefficients and accepts bytes; slave is the encoder.
interface byte_encode_stream_if #(
  parameter int unsigned COEFF_W = 12
);
  logic [COEFF_W-1:0] coeff;
  logic               coeff_valid;
  logic               coeff_ready;
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               byte_ready;

  modport master (
    output coeff, coeff_valid, byte_ready,
    input  coeff_ready, byte_data, byte_valid
  );

  modport slave (
    input  coeff, coeff_valid, byte_ready,
    output coeff_ready, byte_data, byte_valid
  );
endinterface

// File: rtl/byte_encode_stream.sv
// ByteEncode_d: packs N_COEFF d-bit coefficients LSB-first into a byte stream.
// Optional BYTE_ENCODE_RANGE_CHECK_EN adds a sticky range_err output.
module byte_encode_stream #(
  parameter int unsigned N_COEFF = 256,
  parameter int unsigned COEFF_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           d,
  byte_encode_stream_if.slave  strm,
  output logic                 busy,
  output logic                 done,
`ifdef BYTE_ENCODE_RANGE_CHECK_EN
  output logic                 range_err,
`endif
  output logic                 err
);

  localparam int unsigned CCNT_W = $clog2(N_COEFF + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [19:0]       acc;
  logic [4:0]        cnt;
  logic [CCNT_W-1:0] ccnt;
  logic [3:0]        d_q;
  logic              err_q;

  logic        d_ok, start_ok, accept, emit, ccnt_full;
  logic [19:0] mask, coeff_ext;
  logic        coeff_ready_c, byte_valid_c, busy_c, done_c;

  assign d_ok      = (d != 4'd0) && (d <= 4'd12);
  assign start_ok  = (state == IDLE) && start && d_ok;
  assign ccnt_full = (ccnt == CCNT_W'(N_COEFF));
  assign accept    = strm.coeff_valid && coeff_ready_c;
  assign emit      = byte_valid_c && strm.byte_ready;
  assign mask      = (20'd1 << d_q) - 20'd1;
  assign coeff_ext = 20'(strm.coeff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The final emit goes straight to DONE so done follows the last byte by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN:  if (ccnt_full && ((cnt == 5'd0) || (emit && (cnt == 5'd8)))) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    coeff_ready_c = 1'b0;
    byte_valid_c  = 1'b0;
    busy_c        = 1'b0;
    done_c        = 1'b0;
    case (state)
      RUN: begin
        busy_c        = 1'b1;
        coeff_ready_c = (cnt < 5'd8) && !ccnt_full;
        byte_valid_c  = (cnt >= 5'd8);
      end
      DONE: done_c = 1'b1;
      default: ;
    endcase
  end

  assign strm.coeff_ready = coeff_ready_c;
  assign strm.byte_valid  = byte_valid_c;
  assign strm.byte_data   = acc[7:0];
  assign busy             = busy_c;
  assign done             = done_c;
  assign err              = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      ccnt  <= '0;
      d_q   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && !d_ok;
      if (start_ok) begin
        d_q  <= d;
        acc  <= '0;
        cnt  <= '0;
        ccnt <= '0;
      end else if (accept) begin
        acc  <= acc | ((coeff_ext & mask) << cnt);
        cnt  <= cnt + {1'b0, d_q};
        ccnt <= ccnt + CCNT_W'(1);
      end else if (emit) begin
        acc <= acc >> 8;
        cnt <= cnt - 5'd8;
      end
    end
  end

`ifdef BYTE_ENCODE_RANGE_CHECK_EN
  logic range_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q <= 1'b0;
    end else if (start_ok) begin
      range_q <= 1'b0;
    end else if (accept && (((coeff_ext & ~mask) != 20'd0) ||
                            ((d_q == 4'd12) && (coeff_ext >= 20'd3329)))) begin
      range_q <= 1'b1;
    end
  end

  assign range_err = range_q;
`endif

endmodule
